vram_port_arbiter: RTL and testbench

//  Shares the single VRAM port between the CPU write path (the bus-to-GPU bridge) and display scanout reads.
//  CPU writes are queued in a small FIFO. Scanout reads win by default. A starvation guard forces a

---
 rtl/vram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one VRAM port between queued CPU writes and scanout reads
// Reads win by default. After STARVE_LIMIT consecutive read grants with writes
// pending, one write slot is forced.
// Ports: clk/rst (sync, active-high); wr_* CPU write request into FIFO, wr_overflow
//   sticky drop flag; rd_* scanout read request/grant and registered return data;
//   mem_* registered VRAM strobes/address/data and mem_rdata return; fifo_level.
// Optional: VRAM_ARB_STATS_EN adds stat_wr_cnt (mem_we cycles) and
//   stat_starve_cnt (cycles with rd_valid high but a write forced), 16-bit wrapping.
module vram_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int RD_LATENCY   = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [ADDR_W-1:0]               wr_addr,
   input  logic [DATA_W-1:0]               wr_data,
   output logic                            wr_overflow,
   input  logic                            rd_valid,
   output logic                            rd_ready,
   input  logic [ADDR_W-1:0]               rd_addr,
   output logic [DATA_W-1:0]               rd_data,
   output logic                            rd_data_valid,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   output logic                            mem_we,
   output logic                            mem_re,
   input  logic [DATA_W-1:0]               mem_rdata,
`ifdef VRAM_ARB_STATS_EN
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [15:0]                     stat_wr_cnt,
   output logic [15:0]                     stat_starve_cnt
`else
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`endif
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
   logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fd [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wp, r_rp;
   logic [LVL_W-1:0]  r_lvl;
   logic [SC_W-1:0]   r_sc;
   logic              r_we, r_re, r_ovf, r_dv;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic [RD_LATENCY:0] r_vp;
   logic w_pend, w_full, w_push, w_rd, w_wr;
   assign w_pend = r_lvl != '0;
   assign w_full = r_lvl == LVL_W'(FIFO_DEPTH);
   // a full FIFO drops the write even if a pop happens this cycle
   assign w_push = wr_valid && !w_full;
   assign w_rd   = rd_valid && !(w_pend && r_sc >= SC_W'(STARVE_LIMIT));
   assign w_wr   = !w_rd && w_pend;
   assign wr_ready      = !w_full;
   assign wr_overflow   = r_ovf;
   assign rd_ready      = w_rd;
   assign rd_data       = r_rdata;
   assign rd_data_valid = r_dv;
   assign mem_addr      = r_addr;
   assign mem_wdata     = r_wdata;
   assign mem_we        = r_we;
   assign mem_re        = r_re;
   assign fifo_level    = r_lvl;
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fa[r_wp] <= wr_addr;
         r_fd[r_wp] <= wr_data;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_lvl   <= '0;
         r_sc    <= '0;
         r_we    <= 1'b0;
         r_re    <= 1'b0;
         r_ovf   <= 1'b0;
         r_dv    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_vp    <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_wr) r_rp <= r_rp + 1'b1;
         r_lvl <= r_lvl + LVL_W'(w_push) - LVL_W'(w_wr);
         // starvation count only advances while reads are bypassing pending writes
         r_sc  <= (w_rd && w_pend) ? ((r_sc == SC_W'(STARVE_LIMIT)) ? r_sc : r_sc + 1'b1) : '0;
         r_we  <= w_wr;
         r_re  <= w_rd;
         if (w_rd) begin
            r_addr <= rd_addr;
         end else if (w_wr) begin
            r_addr  <= r_fa[r_rp];
            r_wdata <= r_fd[r_rp];
         end
         // tap RD_LATENCY marks the cycle mem_rdata holds the granted read's data
         r_vp <= {r_vp[RD_LATENCY-1:0], w_rd};
         r_dv <= r_vp[RD_LATENCY];
         if (r_vp[RD_LATENCY]) r_rdata <= mem_rdata;
         r_ovf <= r_ovf | (wr_valid & w_full);
      end
   end
`ifdef VRAM_ARB_STATS_EN
   logic [15:0] r_swc, r_ssc;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_swc <= '0;
         r_ssc <= '0;
      end else begin
         if (r_we) r_swc <= r_swc + 1'b1;
         if (rd_valid && w_wr) r_ssc <= r_ssc + 1'b1;
      end
   end
   assign stat_wr_cnt     = r_swc;
   assign stat_starve_cnt = r_ssc;
`endif
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed self-checking bench for vram_port_arbiter
module tb_vram_port_arbiter;
   logic        clk = 1'b0;
   logic        rst, wr_valid, wr_ready, wr_overflow, rd_valid, rd_ready, rd_data_valid;
   logic        mem_we, mem_re;
   logic [15:0] wr_addr, wr_data, rd_addr, rd_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  fifo_level;
   int          total = 0, bad = 0;
`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stat_wr_cnt, stat_starve_cnt;
`endif
   vram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_overflow(wr_overflow),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata),
`ifdef VRAM_ARB_STATS_EN
      .fifo_level(fifo_level), .stat_wr_cnt(stat_wr_cnt), .stat_starve_cnt(stat_starve_cnt)
`else
      .fifo_level(fifo_level)
`endif
   );
   always #5 clk = ~clk;
   // VRAM model: one-cycle read latency, data = address inverted
   always @(posedge clk) mem_rdata <= mem_re ? (mem_addr ^ 16'hFFFF) : 16'h0000;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      tick; tick;
      #1;
      total++;
      if ({wr_ready, wr_overflow, rd_ready, rd_data_valid, mem_we, mem_re} !== 6'b100000) begin
         bad++; $display("FAIL reset_flags got=%b want=100000", {wr_ready, wr_overflow, rd_ready, rd_data_valid, mem_we, mem_re});
      end
      total++;
      if ({rd_data, mem_addr, mem_wdata, 13'(fifo_level)} !== 61'd0) begin
         bad++; $display("FAIL reset_data rd_data=%h mem_addr=%h mem_wdata=%h level=%0d want all 0", rd_data, mem_addr, mem_wdata, fifo_level);
      end
`ifdef VRAM_ARB_STATS_EN
      total++;
      if ({stat_wr_cnt, stat_starve_cnt} !== 32'd0) begin
         bad++; $display("FAIL reset_stats got=%h/%h want 0/0", stat_wr_cnt, stat_starve_cnt);
      end
`endif
      rst = 1'b0;
   endtask
   task automatic test_single_write;
      for (int c = 0; c < 4; c++) begin
         tick;
         wr_valid = (c == 0); wr_addr = 16'h0010; wr_data = 16'hBEEF; rd_valid = 1'b0;
         #1;
         total++;
         if (mem_we !== (c == 2)) begin
            bad++; $display("FAIL wr_mem_we c=%0d got=%b want=%b", c, mem_we, c == 2);
         end
         total++;
         if (fifo_level !== ((c == 1) ? 3'd1 : 3'd0)) begin
            bad++; $display("FAIL wr_level c=%0d got=%0d want=%0d", c, fifo_level, (c == 1) ? 1 : 0);
         end
         if (c == 2) begin
            total++;
            if (mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
               bad++; $display("FAIL wr_payload got=%h/%h want=0010/beef", mem_addr, mem_wdata);
            end
         end
      end
      wr_valid = 1'b0;
   endtask
   task automatic test_read_stream;
      for (int c = 0; c < 10; c++) begin
         tick;
         rd_valid = (c < 5); rd_addr = 16'h0100 + 16'(c);
         #1;
         total++;
         if (rd_ready !== (c < 5)) begin
            bad++; $display("FAIL rd_ready c=%0d got=%b want=%b", c, rd_ready, c < 5);
         end
         total++;
         if (mem_re !== (c >= 1 && c < 6) || (mem_re && mem_addr !== 16'h0100 + 16'(c - 1))) begin
            bad++; $display("FAIL rd_mem_re c=%0d got=%b addr=%h", c, mem_re, mem_addr);
         end
         total++;
         if (rd_data_valid !== (c >= 3 && c < 8)) begin
            bad++; $display("FAIL rd_dv c=%0d got=%b want=%b", c, rd_data_valid, c >= 3 && c < 8);
         end
         if (c >= 3 && c < 8) begin
            total++;
            if (rd_data !== (16'hFFFF ^ (16'h0100 + 16'(c - 3)))) begin
               bad++; $display("FAIL rd_data c=%0d got=%h want=%h", c, rd_data, 16'hFFFF ^ (16'h0100 + 16'(c - 3)));
            end
         end
      end
      rd_valid = 1'b0;
   endtask
   task automatic test_starvation;
`ifdef VRAM_ARB_STATS_EN
      logic [15:0] wc0, sc0;
      wc0 = stat_wr_cnt; sc0 = stat_starve_cnt;
`endif
      for (int c = 0; c < 13; c++) begin
         tick;
         rd_valid = 1'b1; rd_addr = 16'h0400 + 16'(c);
         wr_valid = (c == 0); wr_addr = 16'h0200; wr_data = 16'h1234;
         #1;
         total++;
         if (rd_ready !== (c != 9)) begin
            bad++; $display("FAIL starve_rd_ready c=%0d got=%b want=%b", c, rd_ready, c != 9);
         end
         total++;
         if (mem_we !== (c == 10) || mem_re !== (c >= 1 && c != 10)) begin
            bad++; $display("FAIL starve_strobes c=%0d we=%b re=%b", c, mem_we, mem_re);
         end
         if (c == 10) begin
            total++;
            if (mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
               bad++; $display("FAIL starve_payload got=%h/%h want=0200/1234", mem_addr, mem_wdata);
            end
         end
      end
      rd_valid = 1'b0; wr_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick;
`ifdef VRAM_ARB_STATS_EN
      total++;
      if (stat_wr_cnt !== wc0 + 16'd1 || stat_starve_cnt !== sc0 + 16'd1) begin
         bad++; $display("FAIL stats got=%0d/%0d want=%0d/%0d", stat_wr_cnt, stat_starve_cnt, wc0 + 16'd1, sc0 + 16'd1);
      end
`endif
   endtask
   task automatic test_overflow;
      for (int c = 0; c < 13; c++) begin
         tick;
         wr_valid = (c < 5); rd_valid = (c < 5);
         wr_addr = 16'h0300 + 16'(c); wr_data = 16'hA000 + 16'(c); rd_addr = 16'h0500;
         #1;
         if (c < 5) begin
            total++;
            if (wr_ready !== (c != 4)) begin
               bad++; $display("FAIL ovf_wr_ready c=%0d got=%b want=%b", c, wr_ready, c != 4);
            end
         end
         total++;
         if (wr_overflow !== (c >= 5)) begin
            bad++; $display("FAIL ovf_flag c=%0d got=%b want=%b", c, wr_overflow, c >= 5);
         end
         total++;
         if (mem_we !== (c >= 6 && c <= 9)) begin
            bad++; $display("FAIL ovf_mem_we c=%0d got=%b want=%b", c, mem_we, c >= 6 && c <= 9);
         end
         if (c >= 6 && c <= 9) begin
            total++;
            if (mem_addr !== 16'h0300 + 16'(c - 6) || mem_wdata !== 16'hA000 + 16'(c - 6)) begin
               bad++; $display("FAIL ovf_payload c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, 16'h0300 + 16'(c - 6), 16'hA000 + 16'(c - 6));
            end
         end
         if (c == 5 || c == 10) begin
            total++;
            if (fifo_level !== ((c == 5) ? 3'd4 : 3'd0)) begin
               bad++; $display("FAIL ovf_level c=%0d got=%0d want=%0d", c, fifo_level, (c == 5) ? 4 : 0);
            end
         end
      end
   endtask
   task automatic test_reset_inflight;
      for (int c = 0; c < 12; c++) begin
         tick;
         rst = (c == 5);
         wr_valid = (c < 3); rd_valid = (c < 5);
         wr_addr = 16'h0600 + 16'(c); wr_data = 16'h5500 + 16'(c); rd_addr = 16'h0700 + 16'(c);
         #1;
         if (c == 4) begin
            total++;
            if (fifo_level !== 3'd3 || wr_overflow !== 1'b1) begin
               bad++; $display("FAIL pre_rst level=%0d ovf=%b want 3/1", fifo_level, wr_overflow);
            end
         end
         if (c >= 6) begin
            total++;
            if ({rd_data_valid, mem_we, mem_re, wr_overflow, wr_ready} !== 5'b00001 || fifo_level !== 3'd0) begin
               bad++; $display("FAIL post_rst c=%0d dv/we/re/ovf/rdy=%b level=%0d want 00001/0", c, {rd_data_valid, mem_we, mem_re, wr_overflow, wr_ready}, fifo_level);
            end
         end
      end
   endtask
   initial begin
      test_reset;
      test_single_write;
      test_read_stream;
      test_starvation;
      test_overflow;
      test_reset_inflight;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
